// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the five-stage RV core.
// Resolves every hazard that forwarding cannot: load-use, multi-cycle (div/rem)
// RAW/WAW via a destination scoreboard, outstanding multi-cycle limit, data
// memory wait and taken-branch flush.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   id_*                decode-stage instruction: sources, destination, multi-cycle flag
//   ex_*                execute-stage destination, load flag, branch redirect
//   mc_done/mc_rd_addr  multi-cycle unit writeback
//   mem_busy            data memory not ready
//   pc_hold, ifid_hold, ifid_flush, idex_bubble, mem_freeze  pipeline controls
//   mc_pending          scoreboard, bit n set while a multi-cycle write to xn is in flight
//   hazard_state        registered cause of the last stall (debug)
//
// Optional feature: define HAZARD_PERF_EN to add perf_stall_cnt and
// perf_flush_cnt (XLEN-bit saturating cycle counters).
//
// Latency: controls are combinational (0 cycles); scoreboard and state update
// at the clock edge and are visible the following cycle.

`ifndef XLEN
`define XLEN 32
`endif

module hazard_ctrl #(
    parameter int MC_MAX_OUTSTANDING = 2,
    parameter int XLEN               = `XLEN
) (
    input  logic        clk,
    input  logic        rst,
    // decode stage
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_addr,
    input  logic        id_rs1_re,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_rs2_re,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_rdwe,
    input  logic        id_is_mc,
    // execute stage
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_rdwe,
    input  logic        ex_is_load,
    input  logic        ex_branch_taken,
    // multi-cycle unit writeback
    input  logic        mc_done,
    input  logic [4:0]  mc_rd_addr,
    // data memory
    input  logic        mem_busy,
    // pipeline controls
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        mem_freeze,
    output logic [31:0] mc_pending,
    output logic [1:0]  hazard_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [XLEN-1:0] perf_stall_cnt,
    output logic [XLEN-1:0] perf_flush_cnt
`endif
);

    // Wide enough for the largest supported limit (4).
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MC_MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_FREEZE = 2'd1,
        ST_LOAD_STALL = 2'd2,
        ST_MC_WAIT    = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic [31:0]        pending_q;
    logic [31:0]        pending_nxt;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_nxt;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic use1;
    logic use2;
    logic load_use;
    logic sb_haz;
    logic mc_full;
    logic stall;

    assign use1 = id_valid & id_rs1_re & (id_rs1_addr != 5'd0);
    assign use2 = id_valid & id_rs2_re & (id_rs2_addr != 5'd0);

    assign load_use = ex_is_load & ex_rdwe & (ex_rd_addr != 5'd0) &
                      ((use1 & (id_rs1_addr == ex_rd_addr)) |
                       (use2 & (id_rs2_addr == ex_rd_addr)));

    // RAW on either source, or WAW on the destination, against an in-flight
    // multi-cycle result.
    assign sb_haz = (use1 & pending_q[id_rs1_addr]) |
                    (use2 & pending_q[id_rs2_addr]) |
                    (id_valid & id_rdwe & (id_rd_addr != 5'd0) & pending_q[id_rd_addr]);

    assign mc_full = id_valid & id_is_mc & (count_q == CNT_MAX);

    assign stall = load_use | sb_haz | mc_full;

    // ------------------------------------------------------------------
    // Control outputs and next state (priority: mem_busy, branch, stall)
    // ------------------------------------------------------------------
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mem_freeze  = 1'b0;
        state_nxt   = ST_RUN;

        if (mem_busy) begin
            // Whole pipe frozen; a taken branch in EX simply waits in place.
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            mem_freeze = 1'b1;
            state_nxt  = ST_MEM_FREEZE;
        end else if (ex_branch_taken) begin
            // Decode holds a wrong-path instruction, so its stalls are moot.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = ST_RUN;
        end else if (stall) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = (sb_haz | mc_full) ? ST_MC_WAIT : ST_LOAD_STALL;
        end

        // Controls must be quiet while reset is held, regardless of inputs.
        if (rst) begin
            pc_hold     = 1'b0;
            ifid_hold   = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            mem_freeze  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    assign hazard_state = state_q;

    // ------------------------------------------------------------------
    // Scoreboard of in-flight multi-cycle destinations
    // ------------------------------------------------------------------
    logic issue;
    logic issue_mc;
    logic done_dec;

    assign issue    = id_valid & ~pc_hold & ~ifid_flush;
    assign issue_mc = issue & id_is_mc & id_rdwe & (id_rd_addr != 5'd0);
    // A stray completion with nothing outstanding must not wrap the count.
    assign done_dec = mc_done & (count_q != '0);

    always_comb begin
        pending_nxt = pending_q;
        // Clear first so a same-cycle set of the same register wins.
        if (mc_done) begin
            pending_nxt[mc_rd_addr] = 1'b0;
        end
        if (issue_mc) begin
            pending_nxt[id_rd_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_comb begin
        count_nxt = count_q;
        if (issue_mc && mc_done) begin
            count_nxt = count_q;
        end else if (issue_mc) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (done_dec) begin
            count_nxt = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_nxt;
            count_q   <= count_nxt;
        end
    end

    assign mc_pending = pending_q;

`ifdef HAZARD_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pc_hold && (perf_stall_cnt != {XLEN{1'b1}})) begin
                perf_stall_cnt <= perf_stall_cnt + XLEN'(1);
            end
            if (ifid_flush && (perf_flush_cnt != {XLEN{1'b1}})) begin
                perf_flush_cnt <= perf_flush_cnt + XLEN'(1);
            end
        end
    end
`endif

endmodule
